// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared constants for the I2C register sequencer: engine opcodes, FSM encoding
// and the byte-count clamp used when a transaction is accepted.
package i2c_reg_sequencer_pkg;

  localparam int MAX_BYTES = 4;
  localparam int STEP_W    = 4;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_READ  = 2'b10,
    OP_WRITE = 2'b11
  } i2c_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE,
    ST_FINISH
  } seq_state_e;

  // A zero count still moves one byte; anything above MAX_BYTES saturates.
  function automatic logic [2:0] clamp_count(input logic [2:0] bc);
    if (bc == 3'd0) return 3'd1;
    if (bc > 3'(MAX_BYTES)) return 3'(MAX_BYTES);
    return bc;
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer_step_decode.sv
// Combinational map from (rw, step, byte count) to the engine opcode and byte
// for that step, plus a flag marking the final STOP step.
module i2c_step_decode
  import i2c_reg_sequencer_pkg::*;
(
  input  logic                   rw,
  input  logic [STEP_W-1:0]      step,
  input  logic [2:0]             num_bytes,
  input  logic [6:0]             dev_addr,
  input  logic [7:0]             reg_addr,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic [1:0]             opcode,
  output logic [7:0]             tx_byte,
  output logic                   is_last
);

  logic [STEP_W-1:0]      last_step;
  logic [1:0]             data_idx;
  logic [8*MAX_BYTES-1:0] wr_shift;

  always_comb begin
    // write: S, A+W, R, D0..DN-1, P   read: S, A+W, R, Sr, A+R, RD x N, P
    last_step = rw ? STEP_W'(5) + STEP_W'(num_bytes) : STEP_W'(3) + STEP_W'(num_bytes);
    data_idx  = 2'(step - STEP_W'(3));
    wr_shift  = wr_data << {data_idx, 3'b000};
    is_last   = (step == last_step);
    opcode    = OP_START;
    tx_byte   = '0;
    if (step == '0) begin
      opcode = OP_START;
    end else if (is_last) begin
      opcode = OP_STOP;
    end else if (step == STEP_W'(1)) begin
      opcode  = OP_WRITE;
      tx_byte = {dev_addr, 1'b0};
    end else if (step == STEP_W'(2)) begin
      opcode  = OP_WRITE;
      tx_byte = reg_addr;
    end else if (!rw) begin
      opcode  = OP_WRITE;
      tx_byte = wr_shift[8*MAX_BYTES-1 -: 8];
    end else if (step == STEP_W'(3)) begin
      opcode = OP_START;
    end else if (step == STEP_W'(4)) begin
      opcode  = OP_WRITE;
      tx_byte = {dev_addr, 1'b1};
    end else begin
      opcode = OP_READ;
    end
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register read/write sequencer that drives a byte-level I2C engine through a
// START / address / register / data / STOP sequence with an enable handshake.
//   state   | meaning
//   IDLE    | waiting for start; latches request on accept
//   ISSUE   | present opcode/byte for current step, raise enable
//   WAIT    | hold engine outputs until complete
//   RELEASE | enable low one cycle so the engine drops complete
//   FINISH  | done pulse, back to IDLE
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rw,
  input  logic [6:0]             devAddr,
  input  logic [7:0]             regAddr,
  input  logic [2:0]             byteCount,
  input  logic [8*MAX_BYTES-1:0] wrData,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rdData,
  output logic [1:0]             i2cInstruction,
  output logic                   i2cEnable,
  output logic [7:0]             i2cByteToSend,
  input  logic                   i2cComplete,
  input  logic [7:0]             i2cByteReceived
);

  seq_state_e             state, state_nxt;
  logic [STEP_W-1:0]      step;
  logic                   lat_rw;
  logic [6:0]             lat_dev;
  logic [7:0]             lat_reg;
  logic [2:0]             lat_n;
  logic [8*MAX_BYTES-1:0] lat_wr;
  logic [1:0]             dec_op;
  logic [7:0]             dec_byte;
  logic                   dec_last;
  logic                   accept, capture, advance;

  i2c_step_decode u_decode (
    .rw        (lat_rw),
    .step      (step),
    .num_bytes (lat_n),
    .dev_addr  (lat_dev),
    .reg_addr  (lat_reg),
    .wr_data   (lat_wr),
    .opcode    (dec_op),
    .tx_byte   (dec_byte),
    .is_last   (dec_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    capture        = 1'b0;
    advance        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    i2cEnable      = 1'b0;
    i2cInstruction = OP_START;
    i2cByteToSend  = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy           = 1'b1;
        i2cEnable      = 1'b1;
        i2cInstruction = dec_op;
        i2cByteToSend  = dec_byte;
        state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        busy           = 1'b1;
        i2cEnable      = 1'b1;
        i2cInstruction = dec_op;
        i2cByteToSend  = dec_byte;
        if (i2cComplete) begin
          capture   = (dec_op == OP_READ);
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        busy = 1'b1;
        if (dec_last) begin
          state_nxt = ST_FINISH;
        end else begin
          advance   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // rdData is only cleared by a read request so a write leaves the last result intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      step    <= '0;
      lat_rw  <= 1'b0;
      lat_dev <= '0;
      lat_reg <= '0;
      lat_n   <= 3'd1;
      lat_wr  <= '0;
      rdData  <= '0;
    end else begin
      if (accept) begin
        step    <= '0;
        lat_rw  <= rw;
        lat_dev <= devAddr;
        lat_reg <= regAddr;
        lat_n   <= clamp_count(byteCount);
        lat_wr  <= wrData;
        if (rw) rdData <= '0;
      end else if (advance) begin
        step <= step + STEP_W'(1);
      end
      if (capture) rdData <= {rdData[8*MAX_BYTES-9:0], i2cByteReceived};
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural byte engine and an
// op logger that records each enable rise, gaps between ops and output stability.
module tb_i2c_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, rw;
  logic [6:0]  devAddr;
  logic [7:0]  regAddr;
  logic [2:0]  byteCount;
  logic [31:0] wrData;
  logic        busy, done;
  logic [31:0] rdData;
  logic [1:0]  i2cInstruction;
  logic        i2cEnable;
  logic [7:0]  i2cByteToSend;
  logic        i2cComplete;
  logic [7:0]  i2cByteReceived;

  always #5 clk = ~clk;

  i2c_reg_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .rw              (rw),
    .devAddr         (devAddr),
    .regAddr         (regAddr),
    .byteCount       (byteCount),
    .wrData          (wrData),
    .busy            (busy),
    .done            (done),
    .rdData          (rdData),
    .i2cInstruction  (i2cInstruction),
    .i2cEnable       (i2cEnable),
    .i2cByteToSend   (i2cByteToSend),
    .i2cComplete     (i2cComplete),
    .i2cByteReceived (i2cByteReceived)
  );

  // Byte engine: completes eng_delay cycles after enable, holds complete until enable drops.
  int         eng_delay;
  int         eng_cnt;
  int         rx_idx;
  logic [7:0] rx_data [0:3];

  always @(posedge clk) begin
    if (start && !busy) rx_idx <= 0;
    if (rst || !i2cEnable) begin
      i2cComplete <= 1'b0;
      eng_cnt     <= 0;
    end else if (!i2cComplete) begin
      if (eng_cnt >= eng_delay) begin
        i2cComplete <= 1'b1;
        if (i2cInstruction == 2'b10) begin
          i2cByteReceived <= rx_data[rx_idx[1:0]];
          rx_idx          <= rx_idx + 1;
        end
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  logic [9:0] op_log [0:255];
  int         op_cnt, done_cnt, unstable, gap_ones, gap_bad, gap_len;
  logic       en_prev;
  logic [9:0] op_prev;

  always @(negedge clk) begin
    if (i2cEnable && !en_prev) begin
      op_log[op_cnt[7:0]] <= {i2cInstruction, i2cByteToSend};
      op_cnt <= op_cnt + 1;
      if (gap_len == 1)     gap_ones <= gap_ones + 1;
      else if (gap_len > 1) gap_bad  <= gap_bad + 1;
    end
    if (i2cEnable && en_prev && ({i2cInstruction, i2cByteToSend} != op_prev)) unstable <= unstable + 1;
    if (busy && !i2cEnable) gap_len <= gap_len + 1;
    else                    gap_len <= 0;
    if (done) done_cnt <= done_cnt + 1;
    en_prev <= i2cEnable;
    op_prev <= {i2cInstruction, i2cByteToSend};
  end

  int errors;
  int checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] lg(input int i);
    return op_log[i[7:0]];
  endfunction

  task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                         input logic [2:0] bc, input logic [31:0] wd, input int poke_at,
                         output int base, output int nops, output int ndone);
    int cyc;
    int done0;
    base  = op_cnt;
    done0 = done_cnt;
    rw = r; devAddr = d; regAddr = ra; byteCount = bc; wrData = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 20000) begin
      start = (poke_at != 0 && cyc == poke_at);
      if (start) begin
        rw      = ~r;
        devAddr = 7'h55;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_within_budget", 32'(cyc < 20000), 32'd1);
    repeat (20) @(negedge clk);
    nops  = op_cnt - base;
    ndone = done_cnt - done0;
  endtask

  initial begin
    int base, nops, ndone, u0, g1, gb, cyc;
    logic [9:0] exp_wr [0:4];
    logic [9:0] exp_rd [0:7];

    rst = 1'b1; start = 1'b0; rw = 1'b0; devAddr = '0; regAddr = '0;
    byteCount = '0; wrData = '0; eng_delay = 0;
    rx_data[0] = 8'h12; rx_data[1] = 8'h34; rx_data[2] = 8'h00; rx_data[3] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_enable", 32'(i2cEnable), 32'd0);
    check("rst_instr",  32'(i2cInstruction), 32'd0);
    check("rst_byte",   32'(i2cByteToSend), 32'd0);
    check("rst_rddata", rdData, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-byte write to 0x3C
    run_txn(1'b0, 7'h3C, 8'h00, 3'd1, 32'hAE00_0000, 0, base, nops, ndone);
    exp_wr[0] = 10'h000; exp_wr[1] = 10'h378; exp_wr[2] = 10'h300;
    exp_wr[3] = 10'h3AE; exp_wr[4] = 10'h100;
    check("wr_nops", 32'(nops), 32'd5);
    check("wr_done_pulses", 32'(ndone), 32'd1);
    for (int k = 0; k < 5; k++) check($sformatf("wr_op%0d", k), 32'(lg(base + k)), 32'(exp_wr[k]));
    check("wr_rddata", rdData, 32'd0);

    // Two-byte read from 0x68 reg 0x75
    run_txn(1'b1, 7'h68, 8'h75, 3'd2, 32'h0, 0, base, nops, ndone);
    exp_rd[0] = 10'h000; exp_rd[1] = 10'h3D0; exp_rd[2] = 10'h375; exp_rd[3] = 10'h000;
    exp_rd[4] = 10'h3D1; exp_rd[5] = 10'h200; exp_rd[6] = 10'h200; exp_rd[7] = 10'h100;
    check("rd_nops", 32'(nops), 32'd8);
    check("rd_done_pulses", 32'(ndone), 32'd1);
    for (int k = 0; k < 8; k++) check($sformatf("rd_op%0d", k), 32'(lg(base + k)), 32'(exp_rd[k]));
    check("rd_rddata", rdData, 32'h0000_1234);

    // byteCount 0 write: one data byte, rdData untouched
    run_txn(1'b0, 7'h10, 8'h22, 3'd0, 32'hCAFE_F00D, 0, base, nops, ndone);
    check("wr0_nops", 32'(nops), 32'd5);
    check("wr0_data", 32'(lg(base + 3)), 32'h3CA);
    check("wr0_stop", 32'(lg(base + 4)), 32'h100);
    check("wr0_rddata_kept", rdData, 32'h0000_1234);

    // byteCount 7 write clamps to 4 bytes, MSB first
    run_txn(1'b0, 7'h10, 8'h23, 3'd7, 32'h1122_3344, 0, base, nops, ndone);
    check("wr7_nops", 32'(nops), 32'd8);
    check("wr7_d0", 32'(lg(base + 3)), 32'h311);
    check("wr7_d1", 32'(lg(base + 4)), 32'h322);
    check("wr7_d2", 32'(lg(base + 5)), 32'h333);
    check("wr7_d3", 32'(lg(base + 6)), 32'h344);
    check("wr7_stop", 32'(lg(base + 7)), 32'h100);

    // byteCount 7 read clamps to 4 bytes
    rx_data[0] = 8'hA1; rx_data[1] = 8'hB2; rx_data[2] = 8'hC3; rx_data[3] = 8'hD4;
    run_txn(1'b1, 7'h11, 8'h40, 3'd7, 32'h0, 0, base, nops, ndone);
    check("rd7_nops", 32'(nops), 32'd10);
    check("rd7_op8", 32'(lg(base + 8)), 32'h200);
    check("rd7_stop", 32'(lg(base + 9)), 32'h100);
    check("rd7_rddata", rdData, 32'hA1B2_C3D4);

    // Slow engine: outputs stable in WAIT, exactly one low-enable cycle between ops
    eng_delay = 300;
    u0 = unstable; g1 = gap_ones; gb = gap_bad;
    run_txn(1'b0, 7'h2A, 8'h05, 3'd2, 32'h5566_0000, 0, base, nops, ndone);
    check("slow_nops", 32'(nops), 32'd6);
    check("slow_unstable", 32'(unstable - u0), 32'd0);
    check("slow_gap_one", 32'(gap_ones - g1), 32'd5);
    check("slow_gap_long", 32'(gap_bad - gb), 32'd0);
    check("slow_done_pulses", 32'(ndone), 32'd1);
    eng_delay = 0;

    // Start pulsed mid-transaction with read/other address must be ignored
    run_txn(1'b0, 7'h20, 8'h01, 3'd4, 32'h0102_0304, 10, base, nops, ndone);
    check("poke_nops", 32'(nops), 32'd8);
    check("poke_done_pulses", 32'(ndone), 32'd1);
    check("poke_addr", 32'(lg(base + 1)), 32'h340);
    check("poke_d3", 32'(lg(base + 6)), 32'h304);
    check("poke_rddata_kept", rdData, 32'hA1B2_C3D4);

    // Reset during the third operation, with start held high in the reset cycle
    eng_delay = 5;
    base = op_cnt;
    rw = 1'b0; devAddr = 7'h22; regAddr = 8'h10; byteCount = 3'd2; wrData = 32'hDEAD_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((op_cnt - base) < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached_op3", 32'(cyc < 1000), 32'd1);
    check("mid_enable_pre", 32'(i2cEnable), 32'd1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_enable", 32'(i2cEnable), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_rddata", rdData, 32'd0);
    repeat (5) @(negedge clk);
    check("mid_start_ignored", 32'(busy), 32'd0);
    check("mid_no_stop", 32'(op_cnt - base), 32'd3);
    check("mid_op3", 32'(lg(base + 2)), 32'h310);
    eng_delay = 0;

    // Fresh read after reset, byteCount 0 -> one byte
    rx_data[0] = 8'h5A;
    run_txn(1'b1, 7'h68, 8'h0F, 3'd0, 32'h0, 0, base, nops, ndone);
    check("post_nops", 32'(nops), 32'd7);
    check("post_op3", 32'(lg(base + 3)), 32'h000);
    check("post_op4", 32'(lg(base + 4)), 32'h3D1);
    check("post_op5", 32'(lg(base + 5)), 32'h200);
    check("post_rddata", rdData, 32'h0000_005A);
    check("post_done_pulses", 32'(ndone), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
